fetch_sequencer: RTL and testbench

Producer side of the instruction register load path. The block owns the program counter and drives program memory. It steps the core through the four operating cycles (FETCH, LOAD, EXEC, WRITE) and presents each new instruction on `I_fetch` with a single-cycle `en_IR` strobe, so the instruction register captures exactly one word per instruction and holds it for all four cycles. It sits between program memory and the instruction register, and takes branch, skip and stall requests from the execute logic.

---
 rtl/fetch_sequencer.sv | 69 ++++++
 tb/tb_fetch_sequencer.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: owns the PC, drives program memory and steps the
// core through FETCH/LOAD/EXEC/WRITE, pulsing en_IR once per instruction.
module fetch_sequencer #(
  parameter int                     PC_WIDTH     = 10,
  parameter logic [PC_WIDTH-1:0]    RESET_VECTOR = '0
) (
  input  logic                clk,
  input  logic                rst,
  output logic [PC_WIDTH-1:0] pm_addr,
  input  logic [15:0]         pm_rdata,
  output logic [15:0]         I_fetch,
  output logic                en_IR,
  output logic [1:0]          phase,
  output logic [PC_WIDTH-1:0] pc,
  output logic [PC_WIDTH-1:0] ret_addr,
  input  logic                stall,
  input  logic                branch_take,
  input  logic [PC_WIDTH-1:0] branch_target,
  input  logic                skip_req
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    LOAD  = 2'd1,
    EXEC  = 2'd2,
    WRITE = 2'd3
  } phase_t;

  phase_t              r_phase;
  phase_t              w_phaseNext;
  logic [PC_WIDTH-1:0] r_pc;
  logic [PC_WIDTH-1:0] w_pcNext;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_phase <= FETCH;
      r_pc    <= RESET_VECTOR;
    end else begin
      r_phase <= w_phaseNext;
      r_pc    <= w_pcNext;
    end
  end

  // PC only moves on the WRITE->FETCH edge; branch outranks skip.
  always_comb begin
    w_phaseNext = r_phase;
    w_pcNext    = r_pc;
    case (r_phase)
      FETCH: w_phaseNext = LOAD;
      LOAD:  w_phaseNext = EXEC;
      EXEC:  if (!stall) w_phaseNext = WRITE;
      WRITE: begin
        w_phaseNext = FETCH;
        if (branch_take)   w_pcNext = branch_target;
        else if (skip_req) w_pcNext = r_pc + PC_WIDTH'(2);
        else               w_pcNext = r_pc + PC_WIDTH'(1);
      end
      default: w_phaseNext = FETCH;
    endcase
  end

  assign pm_addr  = r_pc;
  assign pc       = r_pc;
  assign ret_addr = r_pc + PC_WIDTH'(1);
  assign I_fetch  = pm_rdata;
  assign en_IR    = (r_phase == LOAD);
  assign phase    = r_phase;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Randomized self-checking bench for fetch_sequencer against an instruction-level
// model of the fetch/load/exec/write sequence and the PC update rules.
module tb_fetch_sequencer;

   localparam int PCW = 10;
   localparam int PC_MOD = 1024;
   localparam logic [PCW-1:0] RV = 10'h010;

   logic           clk;
   logic           rst;
   logic [PCW-1:0] pm_addr;
   logic [15:0]    pm_rdata;
   logic [15:0]    I_fetch;
   logic           en_IR;
   logic [1:0]     phase;
   logic [PCW-1:0] pc;
   logic [PCW-1:0] ret_addr;
   logic           stall;
   logic           branch_take;
   logic [PCW-1:0] branch_target;
   logic           skip_req;

   logic [15:0] mem [0:PC_MOD-1];
   int          mPc;
   int          errors;
   int          checks;

   fetch_sequencer #(.PC_WIDTH(PCW), .RESET_VECTOR(RV)) dut (
      .clk(clk),
      .rst(rst),
      .pm_addr(pm_addr),
      .pm_rdata(pm_rdata),
      .I_fetch(I_fetch),
      .en_IR(en_IR),
      .phase(phase),
      .pc(pc),
      .ret_addr(ret_addr),
      .stall(stall),
      .branch_take(branch_take),
      .branch_target(branch_target),
      .skip_req(skip_req)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Program memory with a one-cycle synchronous read
   always @(posedge clk) pm_rdata <= mem[pm_addr];

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Randomize every input the sequencer should be ignoring in this phase
   task automatic driveNoise(input bit noise);
      stall         = noise ? 1'($urandom) : 1'b0;
      branch_take   = noise ? 1'($urandom) : 1'b0;
      skip_req      = noise ? 1'($urandom) : 1'b0;
      branch_target = 10'($urandom);
   endtask

   // Runs one full instruction starting at a negedge in FETCH; ends at the next FETCH negedge
   task automatic applyStimulus(input int stallCycles, input bit br, input logic [PCW-1:0] tgt,
                                input bit sk, input bit noise);
      checkOutput("fetch_phase", 32'(phase), 32'd0);
      checkOutput("fetch_pm_addr", 32'(pm_addr), 32'(mPc));
      checkOutput("fetch_pc", 32'(pc), 32'(mPc));
      checkOutput("fetch_ret_addr", 32'(ret_addr), 32'((mPc + 1) % PC_MOD));
      checkOutput("fetch_en_IR", 32'(en_IR), 32'd0);
      driveNoise(noise);
      @(negedge clk);
      checkOutput("load_phase", 32'(phase), 32'd1);
      checkOutput("load_en_IR", 32'(en_IR), 32'd1);
      checkOutput("load_I_fetch", 32'(I_fetch), 32'(mem[mPc]));
      driveNoise(noise);
      for (int i = 0; i <= stallCycles; i++) begin
         @(negedge clk);
         checkOutput("exec_phase", 32'(phase), 32'd2);
         checkOutput("exec_en_IR", 32'(en_IR), 32'd0);
         checkOutput("exec_pc", 32'(pc), 32'(mPc));
         driveNoise(noise);
         stall = (i < stallCycles);
      end
      @(negedge clk);
      checkOutput("write_phase", 32'(phase), 32'd3);
      checkOutput("write_en_IR", 32'(en_IR), 32'd0);
      checkOutput("write_pc", 32'(pc), 32'(mPc));
      stall         = noise ? 1'($urandom) : 1'b0;
      branch_take   = br;
      branch_target = tgt;
      skip_req      = sk;
      @(negedge clk);
      if (br)      mPc = int'(tgt);
      else if (sk) mPc = (mPc + 2) % PC_MOD;
      else         mPc = (mPc + 1) % PC_MOD;
   endtask

   initial begin
      errors = 0;
      checks = 0;
      for (int a = 0; a < PC_MOD; a++) mem[a] = 16'($urandom);
      mem[RV] = 16'hA5A5;
      rst = 1'b1;
      driveNoise(1'b0);
      repeat (2) @(negedge clk);
      checkOutput("reset_phase", 32'(phase), 32'd0);
      checkOutput("reset_pc", 32'(pc), 32'(RV));
      checkOutput("reset_ret_addr", 32'(ret_addr), 32'(RV) + 32'd1);
      checkOutput("reset_en_IR", 32'(en_IR), 32'd0);
      rst = 1'b0;
      mPc = int'(RV);

      $display("[TB] reset and sequencing");
      applyStimulus(0, 1'b0, 10'h000, 1'b0, 1'b0);
      checkOutput("first_write_pc", 32'(pc), 32'h011);

      $display("[TB] stall with pulses in FETCH/LOAD");
      applyStimulus(3, 1'b0, 10'h000, 1'b0, 1'b1);

      $display("[TB] branch vs skip priority");
      applyStimulus(0, 1'b1, 10'h020, 1'b0, 1'b0);
      applyStimulus(0, 1'b1, 10'h155, 1'b1, 1'b0);
      checkOutput("branch_wins", 32'(pm_addr), 32'h155);
      applyStimulus(0, 1'b1, 10'h020, 1'b0, 1'b0);
      applyStimulus(0, 1'b0, 10'h000, 1'b1, 1'b0);
      checkOutput("skip_alone", 32'(pm_addr), 32'h022);

      $display("[TB] wrap-around");
      applyStimulus(0, 1'b1, 10'h3FF, 1'b0, 1'b0);
      applyStimulus(0, 1'b0, 10'h000, 1'b0, 1'b0);
      checkOutput("wrap_plus1", 32'(pc), 32'h000);
      applyStimulus(0, 1'b1, 10'h3FF, 1'b0, 1'b0);
      applyStimulus(1, 1'b0, 10'h000, 1'b1, 1'b0);
      checkOutput("wrap_plus2", 32'(pc), 32'h001);

      $display("[TB] ignored requests outside WRITE");
      applyStimulus(2, 1'b0, 10'h000, 1'b0, 1'b1);

      $display("[TB] async reset in stalled EXEC");
      applyStimulus(0, 1'b1, 10'h0AB, 1'b0, 1'b0);
      stall = 1'b1;
      branch_take = 1'b1;
      branch_target = 10'h200;
      skip_req = 1'b1;
      repeat (4) @(negedge clk);
      checkOutput("stalled_phase", 32'(phase), 32'd2);
      checkOutput("stalled_pc", 32'(pc), 32'h0AB);
      #2 rst = 1'b1;
      #1;
      checkOutput("async_phase", 32'(phase), 32'd0);
      checkOutput("async_pc", 32'(pc), 32'(RV));
      checkOutput("async_en_IR", 32'(en_IR), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      driveNoise(1'b0);
      mPc = int'(RV);
      applyStimulus(0, 1'b0, 10'h000, 1'b0, 1'b0);

      $display("[TB] randomized instruction stream");
      for (int n = 0; n < 40; n++) begin
         applyStimulus(int'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0),
                       10'($urandom), 1'($urandom), 1'b1);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
